// File: rtl/wb_led_matrix_arbiter.sv
// wb_led_matrix_arbiter
//
// Two-master, one-slave Wishbone arbiter in front of the LED matrix slave
// (wb_led_matrix_top). Master 0 is the RV32I core and master 1 is the NoC
// network interface. Arbitration is round-robin per bus cycle: once a master
// is granted, it keeps the grant for as long as it holds cyc. There is no
// pre-emption.
//
// Optional feature (macro WB_LED_ARB_TIMEOUT_EN):
//   A watchdog counts cycles in which a strobe is presented to the slave
//   without an ack. When the count reaches TIMEOUT_CYCLES, the granted master
//   receives a one-cycle err and the strobe to the slave is suppressed for
//   that cycle. Without the macro, m*_err_o are tied low and no counter
//   exists.
//
// Parameters:
//   DW             data bus width (address is fixed at 32 bits)
//   TIMEOUT_CYCLES stalled-strobe cycles before a watchdog error
//   CNT_W          watchdog counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk_i, rst_n             clock, asynchronous active-low reset
//   m0_* / m1_*              Wishbone master-side ports (adr/dat/sel/we/cyc/stb in,
//                            dat/ack/err out)
//   s_*                      Wishbone slave-side ports (adr/dat/sel/we/cyc/stb out,
//                            dat/ack in)
//   gnt_o                    one-hot current grant, 2'b00 when idle
module wb_led_matrix_arbiter #(
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic          clk_i,
    input  logic          rst_n,

    input  logic [31:0]   m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic [31:0]   m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic [31:0]   s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    // Last grantee; reset to 1 so master 0 wins the first tie.
    logic   last_q, last_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: round-robin on ties from idle, direct handover on
    // release when the other master is already waiting.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_q) begin
                        state_d = StGnt0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StGnt1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                    last_d  = 1'b1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_d = StGnt1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_d = StGnt0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant decode and the raw strobe the granted master is presenting.
    // ------------------------------------------------------------------
    logic gnt0;
    logic gnt1;
    logic stb_req;
    logic timeout;

    assign gnt0    = (state_q == StGnt0);
    assign gnt1    = (state_q == StGnt1);
    assign gnt_o   = {gnt1, gnt0};
    assign stb_req = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);

`ifdef WB_LED_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts stalled strobe cycles. An ack in the same cycle as
    // the limit takes priority, so the timeout is gated by !s_ack_i. A
    // dropped strobe (including release of cyc) clears the count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = stb_req && !s_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (!stb_req || s_ack_i || timeout) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Watchdog absent: configuration parameters are intentionally unused.
    localparam logic [31:0] CfgBits = 32'(TIMEOUT_CYCLES) ^ 32'(CNT_W);
    logic unused_cfg;
    assign unused_cfg = ^CfgBits;
    assign timeout    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus multiplexing. Everything is combinational from the registered
    // grant, so a master dropping cyc drops s_cyc_o/s_stb_o in the same
    // cycle, and an ack arriving while idle reaches nobody.
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
            end
            StGnt1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
            end
            default: begin
            end
        endcase
    end

    // The timed-out strobe is withheld from the slave for that cycle.
    assign s_stb_o  = stb_req & ~timeout;
    assign m0_err_o = gnt0 & timeout;
    assign m1_err_o = gnt1 & timeout;

endmodule

// File: tb/tb_wb_led_matrix_arbiter.sv
// Self-checking bench for wb_led_matrix_arbiter: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// an owner/last behavioural model of the arbiter.
module tb_wb_led_matrix_arbiter;

    localparam int unsigned Timeout = 8;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] adr [2];
    logic [31:0] wdat[2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];

    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_led_matrix_arbiter #(
        .DW             (32),
        .TIMEOUT_CYCLES (Timeout),
        .CNT_W          (8)
    ) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .m0_adr_i (adr[0]),
        .m0_dat_i (wdat[0]),
        .m0_sel_i (sel[0]),
        .m0_we_i  (we[0]),
        .m0_cyc_i (cyc[0]),
        .m0_stb_i (stb[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (adr[1]),
        .m1_dat_i (wdat[1]),
        .m1_sel_i (sel[1]),
        .m1_we_i  (we[1]),
        .m1_cyc_i (cyc[1]),
        .m1_stb_i (stb[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus (-1 = nobody), who was granted
    // last, and how many consecutive cycles the owner's strobe has stalled.
    // ------------------------------------------------------------------
    int m_owner = -1;
    int m_last  = 1;
    int m_stall = 0;

    function automatic logic owner_req();
        if (m_owner < 0) return 1'b0;
        return cyc[m_owner] && stb[m_owner];
    endfunction

    function automatic logic exp_timeout();
`ifdef WB_LED_ARB_TIMEOUT_EN
        return owner_req() && !s_ack_i && (m_stall == int'(Timeout));
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 1;
            m_stall = 0;
        end else begin
            if (owner_req() && !s_ack_i && !exp_timeout()) m_stall = m_stall + 1;
            else m_stall = 0;
            if (m_owner < 0) begin
                if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
                else if (cyc[0]) m_owner = 0;
                else if (cyc[1]) m_owner = 1;
                if (m_owner >= 0) m_last = m_owner;
            end else if (!cyc[m_owner]) begin
                if (cyc[1 - m_owner]) begin
                    m_owner = 1 - m_owner;
                    m_last  = m_owner;
                end else begin
                    m_owner = -1;
                end
            end
        end
    end

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk_i) begin
        logic        to;
        logic        e_cyc;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_we;
        to    = exp_timeout();
        e_cyc = 1'b0;
        e_adr = '0;
        e_dat = '0;
        e_sel = '0;
        e_we  = 1'b0;
        if (m_owner >= 0) begin
            e_cyc = cyc[m_owner];
            e_adr = adr[m_owner];
            e_dat = wdat[m_owner];
            e_sel = sel[m_owner];
            e_we  = we[m_owner];
        end
        chk("model gnt_o", 64'(gnt_o), (m_owner == 0) ? 64'd1 : (m_owner == 1) ? 64'd2 : 64'd0);
        chk("model s_cyc_o", 64'(s_cyc_o), 64'(e_cyc));
        chk("model s_stb_o", 64'(s_stb_o), 64'(owner_req() && !to));
        chk("model s_adr_o", 64'(s_adr_o), 64'(e_adr));
        chk("model s_dat_o", 64'(s_dat_o), 64'(e_dat));
        chk("model s_sel_o", 64'(s_sel_o), 64'(e_sel));
        chk("model s_we_o", 64'(s_we_o), 64'(e_we));
        chk("model m0_ack_o", 64'(m0_ack_o), 64'(m_owner == 0 && s_ack_i));
        chk("model m1_ack_o", 64'(m1_ack_o), 64'(m_owner == 1 && s_ack_i));
        chk("model m0_dat_o", 64'(m0_dat_o), (m_owner == 0) ? 64'(s_dat_i) : 64'd0);
        chk("model m1_dat_o", 64'(m1_dat_o), (m_owner == 1) ? 64'(s_dat_i) : 64'd0);
        chk("model m0_err_o", 64'(m0_err_o), 64'(m_owner == 0 && to));
        chk("model m1_err_o", 64'(m1_err_o), 64'(m_owner == 1 && to));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            adr[k]  = '0;
            wdat[k] = '0;
            sel[k]  = '0;
            we[k]   = 1'b0;
            cyc[k]  = 1'b0;
            stb[k]  = 1'b0;
        end
        s_ack_i = 1'b0;
        s_dat_i = '0;
    endtask

    task automatic req(input int k, input logic on);
        cyc[k] = on;
        stb[k] = on;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    int hit;

    initial begin
        idle_all();
        tick();
        tick();
        // Reset state
        chk("reset gnt_o", 64'(gnt_o), 64'd0);
        chk("reset s_cyc_o", 64'(s_cyc_o), 64'd0);
        chk("reset s_stb_o", 64'(s_stb_o), 64'd0);
        chk("reset m0_ack_o", 64'(m0_ack_o), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        // Single write by master 0
        adr[0] = 32'h0000_0004; wdat[0] = 32'h0000_00A5; sel[0] = 4'hF; we[0] = 1'b1;
        req(0, 1'b1);
        #1 chk("latency s_cyc_o", 64'(s_cyc_o), 64'd0);
        tick();
        chk("wr gnt_o", 64'(gnt_o), 64'd1);
        chk("wr s_cyc_o", 64'(s_cyc_o), 64'd1);
        chk("wr s_adr_o", 64'(s_adr_o), 64'h4);
        chk("wr s_dat_o", 64'(s_dat_o), 64'hA5);
        s_ack_i = 1'b1;
        #1 chk("wr m0_ack_o", 64'(m0_ack_o), 64'd1);
        chk("wr m1_ack_o", 64'(m1_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b0; req(0, 1'b0); we[0] = 1'b0;
        #1 chk("wr release s_cyc_o", 64'(s_cyc_o), 64'd0);
        tick();
        chk("wr idle gnt_o", 64'(gnt_o), 64'd0);

        // Simultaneous request after reset, then direct handover
        do_reset();
        req(0, 1'b1); req(1, 1'b1);
        tick();
        chk("tie gnt_o", 64'(gnt_o), 64'd1);
        req(0, 1'b0);
        tick();
        chk("handover gnt_o", 64'(gnt_o), 64'd2);
        req(1, 1'b0);
        tick();
        chk("handover idle", 64'(gnt_o), 64'd0);

        // Back-to-back alternation with per-master read data
        req(0, 1'b1); req(1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            int o;
            logic [31:0] rv;
            o  = i % 2;
            rv = (o == 0) ? 32'h1111_1111 : 32'h2222_2222;
            chk($sformatf("rr%0d gnt_o", i), 64'(gnt_o), (o == 0) ? 64'd1 : 64'd2);
            s_ack_i = 1'b1; s_dat_i = rv;
            #1;
            chk($sformatf("rr%0d rdata", i), (o == 0) ? 64'(m0_dat_o) : 64'(m1_dat_o), 64'(rv));
            chk($sformatf("rr%0d other dat", i), (o == 0) ? 64'(m1_dat_o) : 64'(m0_dat_o), 64'd0);
            tick();
            s_ack_i = 1'b0; s_dat_i = '0; req(o, 1'b0);
            tick();
            req(o, 1'b1);
        end
        req(0, 1'b0); req(1, 1'b0);
        tick();
        tick();

        // Master 1 holds, master 0 waits, master 1 drops mid-strobe
        req(1, 1'b1);
        tick();
        req(0, 1'b1);
        tick();
        chk("hold no preempt", 64'(gnt_o), 64'd2);
        req(1, 1'b0);
        #1 chk("drop s_cyc_o", 64'(s_cyc_o), 64'd0);
        chk("drop s_stb_o", 64'(s_stb_o), 64'd0);
        tick();
        chk("drop then m0", 64'(gnt_o), 64'd1);
        req(0, 1'b0);
        tick();
        tick();

        // Watchdog
        req(0, 1'b1);
        tick();
        chk("wd first stb", 64'(s_stb_o), 64'd1);
        hit = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (m0_err_o && hit == 0) begin
                hit = k;
                chk("wd stb suppressed", 64'(s_stb_o), 64'd0);
            end
        end
`ifdef WB_LED_ARB_TIMEOUT_EN
        chk("wd err cycle", 64'(hit), 64'(Timeout));
`else
        chk("wd err absent", 64'(hit), 64'd0);
`endif
        req(0, 1'b0);
        tick();
        tick();

        // Reset during a master 1 transfer
        req(1, 1'b1);
        tick();
        chk("pre-reset gnt_o", 64'(gnt_o), 64'd2);
        req(0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async rst gnt_o", 64'(gnt_o), 64'd0);
        chk("async rst s_cyc_o", 64'(s_cyc_o), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post-reset tie", 64'(gnt_o), 64'd1);
        idle_all();
        tick();
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (cyc[k]) cyc[k] = ($urandom_range(7) != 0);
                else cyc[k] = ($urandom_range(2) == 0);
                stb[k]  = ($urandom_range(3) != 0);
                adr[k]  = $urandom;
                wdat[k] = $urandom;
                sel[k]  = 4'($urandom);
                we[k]   = 1'($urandom);
            end
            s_ack_i = ($urandom_range(2) == 0);
            s_dat_i = $urandom;
            tick();
        end
        idle_all();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
